sc_matmul_ctrl: RTL

SC_MATMUL_CTRL -- requirements
Module: sc_matmul_ctrl

---
 rtl/sc_matmul_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sc_matmul_ctrl.sv
// sc_matmul_ctrl: sequencer and per-element ones counter for a stochastic-computing matrix multiplier
// Ports:
//   clk, rst_n          sole clock, asynchronous active-low reset
//   start, cfgLen       run request (sampled in IDLE) and stream length latched on acceptance
//   abort               optional cancel of a run in LOAD/RUN/DRAIN (only with SC_MATMUL_CTRL_ABORT_EN)
//   busy                high whenever not IDLE
//   sngLoad, sngEn      generator seed pulse and per-bit advance strobe
//   outputData          stochastic product bits from the datapath, PIPE_LAT cycles behind sngEn
//   result              packed ones counts, element k at [k*(LEN_W+1) +: LEN_W+1]
//   resultValid/Ready   result handshake, held in DONE until accepted
// Optional feature macro: SC_MATMUL_CTRL_ABORT_EN
module sc_matmul_ctrl #(
    parameter int BATCH_SIZE      = 4,
    parameter int OUTPUT_FEATURES = 4,
    parameter int LEN_W           = 8,
    parameter int PIPE_LAT        = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 start,
`ifdef SC_MATMUL_CTRL_ABORT_EN
    input  logic                                                 abort,
`endif
    input  logic [LEN_W-1:0]                                     cfgLen,
    output logic                                                 busy,
    output logic                                                 sngLoad,
    output logic                                                 sngEn,
    input  logic [BATCH_SIZE*OUTPUT_FEATURES-1:0]                outputData,
    output logic [BATCH_SIZE*OUTPUT_FEATURES*(LEN_W+1)-1:0]      result,
    output logic                                                 resultValid,
    input  logic                                                 resultReady
);
    localparam int N  = BATCH_SIZE * OUTPUT_FEATURES;
    localparam int CW = LEN_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

    // With no datapath latency there is nothing to drain, so the run ends straight in DONE
    localparam state_t S_POST = (PIPE_LAT == 0) ? S_DONE : S_DRAIN;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_rem;
    logic          w_abort;
    logic          w_accept;
    logic          w_cnt_en;

    assign w_accept = (r_state == S_IDLE) && start;

`ifdef SC_MATMUL_CTRL_ABORT_EN
    assign w_abort = abort && (r_state inside {S_LOAD, S_RUN, S_DRAIN});
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = (r_rem != '0) ? S_RUN : S_POST;
            S_RUN:   w_next = (r_rem == CW'(1)) ? S_POST : S_RUN;
            S_DRAIN: w_next = (r_rem == CW'(1)) ? S_DONE : S_DRAIN;
            S_DONE:  w_next = resultReady ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort)
            w_next = S_IDLE;
    end

    always_comb begin
        busy        = r_state != S_IDLE;
        sngLoad     = r_state == S_LOAD;
        sngEn       = r_state == S_RUN;
        resultValid = r_state == S_DONE;
    end

    // One down-counter serves both phases: stream cycles left in RUN, then drain cycles left in DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rem <= '0;
        else if (w_abort)
            r_rem <= '0;
        else if (w_accept)
            r_rem <= CW'(cfgLen);
        else if (w_next == S_DRAIN && r_state != S_DRAIN)
            r_rem <= CW'(PIPE_LAT);
        else if (r_state == S_RUN || r_state == S_DRAIN)
            r_rem <= r_rem - CW'(1);
    end

    // countEn tracks sngEn through the datapath latency so each counted bit matches its stream cycle
    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign w_cnt_en = sngEn;
        end else begin : g_dly
            logic [PIPE_LAT-1:0] r_dly;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_dly <= '0;
                else if (w_abort)
                    r_dly <= '0;
                else
                    r_dly <= PIPE_LAT'({r_dly, sngEn});
            end
            assign w_cnt_en = r_dly[PIPE_LAT-1];
        end
    endgenerate

    // Counters keep their final value through IDLE and are only cleared by the next accepted start
    for (genvar k = 0; k < N; k++) begin : g_cnt
        logic [CW-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_cnt <= '0;
            else if (w_abort || w_accept)
                r_cnt <= '0;
            else if (w_cnt_en && outputData[k])
                r_cnt <= r_cnt + CW'(1);
        end
        assign result[k*CW +: CW] = r_cnt;
    end

endmodule
